// File: rtl/mips_pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects,
// and the destination-tracking scoreboard entry.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_HAZ = 2'd1,
        ST_FRZ = 2'd2
    } state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Entry rd is stored zero-extended to this width; REG_AW must not exceed it.
    localparam int SB_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               wena;
        logic               load;
    } sb_entry_t;

    localparam int SB_W = $bits(sb_entry_t);

    // $0 is hardwired, so a write to it never creates a dependency.
    function automatic logic src_match(input logic rena, input logic [SB_RD_W-1:0] src,
                                       input sb_entry_t e);
        return rena && e.valid && e.wena && (e.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-deep EX/MEM/WB destination tracker; shifts one stage per unfrozen cycle.
module hazard_scoreboard
    import mips_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            adv_i,
    input  logic [SB_W-1:0] issue_i,
    output logic [SB_W-1:0] ex_o,
    output logic [SB_W-1:0] mem_o,
    output logic [SB_W-1:0] wb_o
);

    sb_entry_t ex_q, mem_q, wb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (adv_i) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= sb_entry_t'(issue_i);
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/freeze/flush controller for a 5-stage MIPS pipeline.
// Define FORWARD_UNIT_EN to enable operand forwarding (only load-use then stalls).
module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_rena,
    input  logic              id_rt_rena,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_wena,
    input  logic              id_is_load,
    input  logic              id_redirect,
    input  logic              mem_busy,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [1:0]        dbg_state,
    output logic [3*SB_W-1:0] dbg_sb
);

    sb_entry_t          issue, ex_e, mem_e, wb_e;
    logic [SB_W-1:0]    ex_v, mem_v, wb_v;
    logic [SB_RD_W-1:0] rs_w, rt_w;
    logic               rs_ex, rs_mem, rt_ex, rt_mem;
    logic               hazard;
    state_e             st_d, st_q;
    logic [CNT_W-1:0]   cnt_q;

    assign rs_w = SB_RD_W'(id_rs);
    assign rt_w = SB_RD_W'(id_rt);

    assign ex_e  = sb_entry_t'(ex_v);
    assign mem_e = sb_entry_t'(mem_v);
    assign wb_e  = sb_entry_t'(wb_v);

    // WB is never consulted: the register file writes before ID reads.
    assign rs_ex  = src_match(id_rs_rena, rs_w, ex_e);
    assign rs_mem = src_match(id_rs_rena, rs_w, mem_e);
    assign rt_ex  = src_match(id_rt_rena, rt_w, ex_e);
    assign rt_mem = src_match(id_rt_rena, rt_w, mem_e);

    always_comb begin
        hazard    = 1'b0;
        fwd_a_sel = FWD_NONE;
        fwd_b_sel = FWD_NONE;
`ifdef FORWARD_UNIT_EN
        hazard    = (rs_ex || rt_ex) && ex_e.load;
        fwd_a_sel = rs_ex ? FWD_EX : (rs_mem ? FWD_MEM : FWD_NONE);
        fwd_b_sel = rt_ex ? FWD_EX : (rt_mem ? FWD_MEM : FWD_NONE);
`else
        hazard    = rs_ex || rs_mem || rt_ex || rt_mem;
`endif
    end

    // The state entered this cycle also drives this cycle's controls, so a
    // memory wait or a hazard takes effect before the next edge.
    always_comb begin
        st_d = ST_RUN;
        if (!rst_n)        st_d = ST_RUN;
        else if (mem_busy) st_d = ST_FRZ;
        else if (hazard)   st_d = ST_HAZ;
    end

    assign pc_hold     = (st_d != ST_RUN);
    assign ifid_hold   = (st_d != ST_RUN);
    assign idex_bubble = (st_d == ST_HAZ);
    assign pipe_freeze = (st_d == ST_FRZ);
    assign ifid_flush  = rst_n && (st_d == ST_RUN) && id_valid && id_redirect;

    always_comb begin
        issue       = '0;
        issue.valid = id_valid && !idex_bubble;
        issue.rd    = SB_RD_W'(id_rd);
        issue.wena  = id_rf_wena;
        issue.load  = id_is_load;
    end

    hazard_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (!pipe_freeze),
        .issue_i (issue),
        .ex_o    (ex_v),
        .mem_o   (mem_v),
        .wb_o    (wb_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_RUN;
            cnt_q <= '0;
        end else begin
            st_q <= st_d;
            if (st_d == ST_HAZ && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
    assign dbg_state = st_q;
    assign dbg_sb    = {ex_v, mem_v, wb_v};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with an expected-result queue; a second
// instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;
    import mips_pipe_pkg::*;

    localparam int AW = 5;
    localparam int W  = 38;
`ifdef FORWARD_UNIT_EN
    localparam int HAZ_PER_USE = 1;
`else
    localparam int HAZ_PER_USE = 2;
`endif

    localparam logic [8:0] C_RUN = 9'b00000_0000;
    localparam logic [8:0] C_HAZ = 9'b11100_0000;
    localparam logic [8:0] C_FRZ = 9'b11001_0000;
    localparam logic [8:0] C_FLS = 9'b00010_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0, id_rs_rena = 1'b0, id_rt_rena = 1'b0;
    logic id_rf_wena = 1'b0, id_is_load = 1'b0, id_redirect = 1'b0, mem_busy = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;

    logic pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze;
    logic [15:0] stall_cnt;
    logic [1:0] fwd_a_sel, fwd_b_sel, dbg_state;
    logic [3*SB_W-1:0] dbg_sb;

    logic s_pc_hold, s_ifid_hold, s_idex_bubble, s_ifid_flush, s_pipe_freeze;
    logic [1:0] s_stall_cnt, s_fwd_a_sel, s_fwd_b_sel, s_dbg_state;
    logic [3*SB_W-1:0] s_dbg_sb;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_rena(id_rs_rena), .id_rt_rena(id_rt_rena), .id_rd(id_rd),
        .id_rf_wena(id_rf_wena), .id_is_load(id_is_load), .id_redirect(id_redirect),
        .mem_busy(mem_busy), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .pipe_freeze(pipe_freeze),
        .stall_cnt(stall_cnt), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .dbg_state(dbg_state), .dbg_sb(dbg_sb)
    );

    pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_rena(id_rs_rena), .id_rt_rena(id_rt_rena), .id_rd(id_rd),
        .id_rf_wena(id_rf_wena), .id_is_load(id_is_load), .id_redirect(id_redirect),
        .mem_busy(mem_busy), .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold),
        .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush), .pipe_freeze(s_pipe_freeze),
        .stall_cnt(s_stall_cnt), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .dbg_state(s_dbg_state), .dbg_sb(s_dbg_sb)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] rs, rt;
        logic          rsen, rten;
        logic [AW-1:0] rd;
        logic          we, ld, redir, busy;
        logic [8:0]    ctl;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic v, input int rs, input int rt, input logic rsen,
                                input logic rten, input int rd, input logic we, input logic ld,
                                input logic redir, input logic busy, input logic [8:0] ctl);
        vec_t r;
        r.v = v; r.rs = AW'(rs); r.rt = AW'(rt); r.rsen = rsen; r.rten = rten;
        r.rd = AW'(rd); r.we = we; r.ld = ld; r.redir = redir; r.busy = busy; r.ctl = ctl;
        return r;
    endfunction

    function automatic vec_t nop(input logic busy, input logic [8:0] ctl);
        return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, busy, ctl);
    endfunction

    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rs_rena = t.rsen; id_rt_rena = t.rten;
        id_rd = t.rd; id_rf_wena = t.we; id_is_load = t.ld; id_redirect = t.redir;
        mem_busy = t.busy;
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name);
        logic [W-1:0] got;
        logic [W-1:0] e;
        got = {pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze, fwd_a_sel, fwd_b_sel,
               s_pc_hold, s_ifid_hold, s_idex_bubble, s_ifid_flush, s_pipe_freeze,
               s_fwd_a_sel, s_fwd_b_sel, stall_cnt, s_stall_cnt, dbg_state};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: got=%0h expected=<empty queue>", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got=%0h expected=%0h", name, got, e);
            end
        end
    endtask

    task automatic fill_table();
`ifdef FORWARD_UNIT_EN
        tv.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 9'b00000_01_00));
        tv.push_back(nop(0, C_RUN));
        tv.push_back(nop(0, C_RUN));
        tv.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, C_RUN));
        tv.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 9'b11100_01_01));
        tv.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 9'b00000_10_10));
        tv.push_back(nop(0, C_RUN));
        tv.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 0, 0, 9'b00000_01_00));
        tv.push_back(nop(0, C_RUN));
        tv.push_back(mk(1, 5, 6, 1, 1, 0, 1, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 0, 0, 1, 1, 8, 1, 0, 1, 0, C_FLS));
        tv.push_back(nop(1, C_FRZ));
        tv.push_back(nop(0, C_RUN));
        tv.push_back(nop(0, C_RUN));
        tv.push_back(nop(0, C_RUN));
`else
        tv.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, C_RUN));
        for (int i = 0; i < 2; i++) tv.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, C_HAZ));
        tv.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, C_RUN));
        for (int i = 0; i < 3; i++) tv.push_back(nop(0, C_RUN));
        tv.push_back(mk(1, 5, 6, 1, 1, 0, 1, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 0, 0, 1, 1, 7, 1, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 7, 7, 0, 0, 8, 0, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, C_RUN));
        for (int i = 0; i < 2; i++) tv.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, C_HAZ));
        tv.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, C_RUN));
        for (int i = 0; i < 2; i++) tv.push_back(nop(0, C_RUN));
        tv.push_back(mk(1, 1, 2, 1, 1, 10, 1, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, C_HAZ));
        for (int i = 0; i < 3; i++) tv.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 1, C_FRZ));
        tv.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, C_HAZ));
        tv.push_back(mk(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN));
        tv.push_back(nop(1, C_FRZ));
        for (int i = 0; i < 3; i++) tv.push_back(nop(0, C_RUN));
        tv.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, C_RUN));
        for (int i = 0; i < 2; i++) tv.push_back(mk(1, 11, 0, 1, 0, 0, 0, 0, 1, 0, C_HAZ));
        tv.push_back(mk(1, 11, 0, 1, 0, 0, 0, 0, 1, 0, C_FLS));
        for (int i = 0; i < 3; i++) tv.push_back(nop(0, C_RUN));
        tv.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, C_RUN));
        tv.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, C_RUN));
        for (int i = 0; i < 2; i++) tv.push_back(mk(1, 12, 13, 1, 1, 0, 0, 0, 0, 0, C_HAZ));
        tv.push_back(mk(1, 12, 13, 1, 1, 0, 0, 0, 0, 0, C_RUN));
        for (int i = 0; i < 2; i++) tv.push_back(nop(0, C_RUN));
`endif
    endtask

    initial begin
        logic [15:0] ecnt;
        logic [1:0]  scnt;
        logic [1:0]  prev_st;

        fill_table();

        // Reset: controls stay low even with busy/redirect asserted.
        drive(mk(1, 3, 3, 1, 1, 3, 1, 1, 1, 1, C_RUN));
        #2;
        check_val("reset_ctl", {pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze,
                  fwd_a_sel, fwd_b_sel, dbg_state}, 64'd0);
        check_val("reset_cnt", {stall_cnt, s_stall_cnt}, 64'd0);
        check_val("reset_sb", dbg_sb, 64'd0);
        check_val("reset_sat_ctl", {s_pc_hold, s_idex_bubble, s_pipe_freeze, s_ifid_flush,
                  s_dbg_state}, 64'd0);
        drive(nop(0, C_RUN));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        ecnt = '0;
        prev_st = ST_RUN;
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i]);
            scnt = (ecnt >= 16'd3) ? 2'd3 : ecnt[1:0];
            exp_q.push_back({tv[i].ctl, tv[i].ctl, ecnt, scnt, prev_st});
            #2;
            check_vec($sformatf("vec%0d", i));
            if (tv[i].ctl[6])      begin ecnt = ecnt + 16'd1; prev_st = ST_HAZ; end
            else if (tv[i].ctl[4]) prev_st = ST_FRZ;
            else                   prev_st = ST_RUN;
        end

        // Reset in the middle of a hazard stall.
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 14, 1, 1, 0, 0, C_RUN));
        @(negedge clk);
        drive(mk(1, 14, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN));
        #2;
        check_val("midhaz_stall", {pc_hold, idex_bubble}, 64'b11);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midhaz_rst_ctl", {pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze,
                  fwd_a_sel, fwd_b_sel, dbg_state}, 64'd0);
        check_val("midhaz_rst_cnt", {stall_cnt, s_stall_cnt}, 64'd0);
        check_val("midhaz_rst_sb", dbg_sb, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_val("midhaz_after_rst", {pc_hold, idex_bubble, pipe_freeze}, 64'd0);

        // Repeated load-use stalls drive the 2-bit counter to saturation.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(mk(1, 0, 0, 0, 0, 20 + k, 1, 1, 0, 0, C_RUN));
            for (int j = 0; j <= HAZ_PER_USE; j++) begin
                @(negedge clk);
                drive(mk(1, 20 + k, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN));
                #2;
                check_val($sformatf("sat_bubble_k%0d_j%0d", k, j), {63'd0, idex_bubble},
                          {63'd0, (j < HAZ_PER_USE)});
            end
        end
        @(negedge clk);
        drive(nop(0, C_RUN));
        #2;
        check_val("sat_cnt16", {48'd0, stall_cnt}, 64'(5 * HAZ_PER_USE));
        check_val("sat_cnt2", {62'd0, s_stall_cnt}, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with clock and reset ports as listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_rs, id_rt  in  REG_AW each  ID source register addresses.
REQ-008 id_rs_rena, id_rt_rena  in  1 each  source actually read (decoder rf_rena1/rf_rena2).
REQ-009 id_rd, id_rf_wena, id_is_load  in  REG_AW/1/1  ID destination, writes RF, is lw.
REQ-010 id_redirect  in  1  ID resolved taken branch/jump (pc_mux_sel not sequential).
REQ-011 mem_busy  in  1  data memory wait request.
REQ-012 pc_hold, ifid_hold  out  1 each  freeze PC and IF/ID register.
REQ-013 idex_bubble  out  1  load NOP into ID/EX.
REQ-014 ifid_flush  out  1  kill instruction in IF/ID.
REQ-015 pipe_freeze  out  1  freeze ID/EX, EX/MEM, MEM/WB.
REQ-016 stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.
REQ-017 fwd_a_sel, fwd_b_sel  out  2 each  operand forwarding selects (FWD_EN only).

Function
REQ-018 The block SHALL track EX, MEM, WB destinations as {valid, rd, wena, load} in a 3-deep scoreboard advancing each unfrozen cycle; entry issued from ID is cleared when idex_bubble=1 or id_valid=0.
REQ-019 A source SHALL match a stage when rena=1, rd equals source, rd!=0 and stage wena=1; WB never matches (RF write-before-read).
REQ-020 Without FWD_EN, hazard SHALL equal any ID source matching EX or MEM.
REQ-021 The FSM SHALL have states RUN, HAZ, FRZ; FRZ has priority over HAZ.
REQ-022 RUN->FRZ when mem_busy=1; RUN->HAZ when hazard=1 and mem_busy=0; HAZ->RUN when hazard clears; FRZ->RUN/HAZ on first cycle mem_busy=0, re-evaluating hazard.
REQ-023 In HAZ, pc_hold=ifid_hold=idex_bubble=1, pipe_freeze=0 (combinational from current hazard, same cycle).
REQ-024 In FRZ, pc_hold=ifid_hold=pipe_freeze=1, idex_bubble=0, scoreboard holds.
REQ-025 ifid_flush SHALL assert for one cycle when id_redirect=1 and the ID instruction is not stalled or frozen; a redirect under stall SHALL be ignored until the stall clears.
REQ-026 stall_cnt SHALL increment once per HAZ cycle, saturating at all-ones; FRZ cycles are not counted.
REQ-027 Back-to-back hazards SHALL keep HAZ with no intervening RUN cycle.

Reset
REQ-028 On rst_n=0, the FSM SHALL go to RUN, scoreboard valids clear, stall_cnt=0 and all outputs 0, asynchronously; reset mid-stall discards the stall.

Configuration
REQ-029 With FORWARD_UNIT_EN defined, hazard SHALL be only a source matching an EX entry with load=1 (one HAZ cycle); fwd_x_sel=2'b01 for an EX match, 2'b10 for a MEM match (EX wins), 2'b00 otherwise.
REQ-030 Without FORWARD_UNIT_EN, fwd_a_sel/fwd_b_sel SHALL tie to 2'b00 and REQ-020 applies.

Structure
REQ-031 Package mips_pipe_pkg SHALL hold the FSM state enum, FWD_NONE/FWD_EX/FWD_MEM constants and the scoreboard-entry struct.
REQ-032 The scoreboard SHALL be sub-module hazard_scoreboard; FSM, match logic and counter stay in the top.

Verification
REQ-033 addu $3 then addu $4,$3,$1 without FWD -> two HAZ cycles, idex_bubble=1 twice, stall_cnt=2.
REQ-034 Same with FORWARD_UNIT_EN -> no stall, fwd_a_sel=01 then 00; lw $3 followed by use -> one HAZ cycle, then fwd=10.
REQ-035 Writer with rd=0 or id_rs_rena=0 -> no stall.
REQ-036 mem_busy=1 for 3 cycles during HAZ -> FRZ 3 cycles, pipe_freeze=1, stall_cnt unchanged, then HAZ resumes.
REQ-037 id_redirect=1 while hazard -> ifid_flush=0 until stall clears, then exactly one cycle of 1.
REQ-038 rst_n low mid-HAZ -> outputs 0 immediately; with CNT_W=2, 5 HAZ cycles -> stall_cnt=3.
